// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: bit-serial adder/subtractor, LSB first, one bit per clock.
// A start request (St) is accepted only while idle. The result, carry/borrow and
// signed-overflow flags are registered together and announced by a one-cycle Done.
// Optional build macro SERIAL_SAT_EN: the result saturates unsigned on carry/borrow
// (add -> all ones, sub -> zero). Cout and Ovf still report the raw condition.
// Handshake: St/Mode/A/B are sampled on the clock edge where St=1 and Busy=0.
// Busy stays high for WIDTH cycles. Done pulses for one cycle when Result, Cout and
// Ovf update. A new St is accepted in the Done cycle.
module serial_addsub_unit #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             R,
   input  logic             St,
   input  logic             Mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Result,
   output logic             Cout,
   output logic             Ovf,
   output logic             Busy,
   output logic             Done,
   output logic             dbg_state
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] acc, opnd, acc_n, res_n;
   logic [CNT_W-1:0] cnt;
   logic             mode_r, cy, a_msb, b_msb;
   logic             x, y, s, cy_n, last_bit, ovf_n;

   assign dbg_state = state;

   // State register.
   always_ff @(posedge CLK or posedge R) begin
      if (R) state <= IDLE;
      else   state <= state_n;
   end

   // One full-adder/full-subtractor bit slice, next state and final-edge values.
   always_comb begin
      state_n  = state;
      x        = acc[0];
      y        = opnd[0];
      s        = x ^ y ^ cy;
      if (mode_r) cy_n = (x & y) | (cy & (x ^ y));
      else        cy_n = (~x & y) | (~x & cy) | (y & cy);
      acc_n    = {s, acc[WIDTH-1:1]};
      last_bit = (cnt == CNT_W'(WIDTH - 1));
      // s is the result MSB on the last bit; MSBs of A and B come from the start capture.
      if (mode_r) ovf_n = (a_msb == b_msb) && (s != a_msb);
      else        ovf_n = (a_msb != b_msb) && (s != a_msb);
`ifdef SERIAL_SAT_EN
      if (cy_n) res_n = mode_r ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
      else      res_n = acc_n;
`else
      res_n = acc_n;
`endif
      case (state)
         IDLE:    if (St) state_n = SHIFT;
         SHIFT:   if (last_bit) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Operand capture, serial shifting and registered result/flags.
   always_ff @(posedge CLK or posedge R) begin
      if (R) begin
         acc    <= '0;
         opnd   <= '0;
         cnt    <= '0;
         mode_r <= 1'b0;
         cy     <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         Result <= '0;
         Cout   <= 1'b0;
         Ovf    <= 1'b0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (St) begin
                  acc    <= A;
                  opnd   <= B;
                  mode_r <= Mode;
                  a_msb  <= A[WIDTH-1];
                  b_msb  <= B[WIDTH-1];
                  cy     <= 1'b0;
                  cnt    <= '0;
                  Busy   <= 1'b1;
               end
            end
            SHIFT: begin
               acc  <= acc_n;
               opnd <= {opnd[0], opnd[WIDTH-1:1]};
               cy   <= cy_n;
               cnt  <= cnt + CNT_W'(1);
               if (last_bit) begin
                  Result <= res_n;
                  Cout   <= cy_n;
                  Ovf    <= ovf_n;
                  Done   <= 1'b1;
                  Busy   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// tb_serial_addsub_unit: directed vectors for the serial add/sub unit at WIDTH=8 and 16.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
// Done is observed in the cycle after edge t0+WIDTH, so a synchronous consumer sees it at t0+WIDTH+1.
module tb_serial_addsub_unit;

   logic        CLK = 1'b0;
   logic        R   = 1'b0;
   logic        st8, mode8, cout8, ovf8, busy8, done8, dbg8;
   logic [7:0]  a8, b8, res8;
   logic        st16, mode16, cout16, ovf16, busy16, done16, dbg16;
   logic [15:0] a16, b16, res16;

   int n_cmp = 0;
   int n_err = 0;

   // Clock.
   always #5 CLK = ~CLK;

   serial_addsub_unit #(.WIDTH(8)) u8 (
      .CLK(CLK), .R(R), .St(st8), .Mode(mode8), .A(a8), .B(b8),
      .Result(res8), .Cout(cout8), .Ovf(ovf8), .Busy(busy8), .Done(done8), .dbg_state(dbg8)
   );

   serial_addsub_unit #(.WIDTH(16)) u16 (
      .CLK(CLK), .R(R), .St(st16), .Mode(mode16), .A(a16), .B(b16),
      .Result(res16), .Cout(cout16), .Ovf(ovf16), .Busy(busy16), .Done(done16), .dbg_state(dbg16)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one operation for a single clock edge.
   task automatic start_op(input int w, input logic m, input logic [15:0] a, input logic [15:0] b);
      @(negedge CLK);
      if (w == 8) begin mode8 = m; a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1; end
      else        begin mode16 = m; a16 = a; b16 = b; st16 = 1'b1; end
      @(negedge CLK);
      st8 = 1'b0; st16 = 1'b0;
   endtask

   // Count falling edges until Done (bounded). Optionally disturb the 8-bit inputs mid-operation.
   task automatic wait_done(input int w, input int disturb_at, output int lat, output int busy_cnt);
      lat = 0;
      busy_cnt = 0;
      while (!(w == 8 ? done8 : done16) && lat < 40) begin
         if (w == 8 ? busy8 : busy16) busy_cnt++;
         if (w == 8 && lat == disturb_at) begin
            st8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; mode8 = ~mode8;
         end
         if (w == 8 && lat == disturb_at + 1) st8 = 1'b0;
         @(negedge CLK);
         lat++;
      end
   endtask

   task automatic expect8(input string tag, input logic [7:0] r, input logic c, input logic v);
      check({tag, "_result"}, res8, r);
      check({tag, "_cout"}, cout8, c);
      check({tag, "_ovf"}, ovf8, v);
   endtask

   task automatic quiet8(input string tag, input int cycles);
      int dn = 0;
      int bz = 0;
      repeat (cycles) begin
         @(negedge CLK);
         if (done8) dn++;
         if (busy8) bz++;
      end
      check({tag, "_no_done"}, dn, 0);
      check({tag, "_no_busy"}, bz, 0);
   endtask

   initial begin
      int lat, bc, gap;
      st8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
      st16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0;

      // Reset state.
      #1 R = 1'b1;
      #1;
      check("rst_result", res8, 8'h00);
      check("rst_flags", {cout8, ovf8, busy8, done8, dbg8}, 5'b0);
      check("rst_16", {res16, cout16, ovf16, busy16, done16, dbg16}, 21'b0);
      repeat (2) @(negedge CLK);
      R = 1'b0;

      // T1: sub A5-83.
      start_op(8, 1'b0, 16'hA5, 16'h83);
      wait_done(8, -1, lat, bc);
      check("t1_latency", lat, 8);
      check("t1_busy_cycles", bc, 8);
      check("t1_busy_at_done", busy8, 1'b0);
      expect8("t1", 8'h22, 1'b0, 1'b0);
      @(negedge CLK);
      check("t1_done_one_cycle", done8, 1'b0);
      check("t1_result_hold", res8, 8'h22);

      // T2: add FF+01.
      start_op(8, 1'b1, 16'hFF, 16'h01);
      wait_done(8, -1, lat, bc);
      check("t2_latency", lat, 8);
`ifdef SERIAL_SAT_EN
      expect8("t2", 8'hFF, 1'b1, 1'b0);
`else
      expect8("t2", 8'h00, 1'b1, 1'b0);
`endif

      // T3: signed overflow on sub, then a borrow.
      start_op(8, 1'b0, 16'h80, 16'h01);
      wait_done(8, -1, lat, bc);
      expect8("t3a", 8'h7F, 1'b0, 1'b1);
      start_op(8, 1'b0, 16'h03, 16'h05);
      wait_done(8, -1, lat, bc);
`ifdef SERIAL_SAT_EN
      expect8("t3b", 8'h00, 1'b1, 1'b0);
`else
      expect8("t3b", 8'hFE, 1'b1, 1'b0);
`endif
      // Add overflow: 0x7F + 0x01 = 0x80.
      start_op(8, 1'b1, 16'h7F, 16'h01);
      wait_done(8, -1, lat, bc);
      expect8("t3c", 8'h80, 1'b0, 1'b1);

      // T4a: St and inputs disturbed at bit 3 are ignored, no extra Done.
      start_op(8, 1'b1, 16'h11, 16'h22);
      wait_done(8, 3, lat, bc);
      check("t4a_latency", lat, 8);
      expect8("t4a", 8'h33, 1'b0, 1'b0);
      quiet8("t4a", 12);

      // T4b: back-to-back, second St in the Done cycle.
      start_op(8, 1'b1, 16'h40, 16'h05);
      wait_done(8, -1, lat, bc);
      expect8("t4b_first", 8'h45, 1'b0, 1'b0);
      mode8 = 1'b0; a8 = 8'h50; b8 = 8'h10; st8 = 1'b1;
      @(negedge CLK);
      st8 = 1'b0;
      wait_done(8, -1, lat, bc);
      gap = lat + 1;
      check("t4b_gap_edges", gap, 9);
      expect8("t4b_second", 8'h40, 1'b0, 1'b0);

      // T5: asynchronous reset at bit 4 of an add.
      start_op(8, 1'b1, 16'h0F, 16'h0F);
      repeat (4) @(negedge CLK);
      R = 1'b1;
      #1;
      check("t5_rst_result", res8, 8'h00);
      check("t5_rst_flags", {cout8, ovf8, busy8, done8, dbg8}, 5'b0);
      @(negedge CLK);
      R = 1'b0;
      quiet8("t5", 12);
      start_op(8, 1'b1, 16'h10, 16'h20);
      wait_done(8, -1, lat, bc);
      check("t5_latency", lat, 8);
      expect8("t5_after", 8'h30, 1'b0, 1'b0);

      // T6: WIDTH=16.
      start_op(16, 1'b1, 16'h1234, 16'h0FFF);
      wait_done(16, -1, lat, bc);
      check("t6_latency", lat, 16);
      check("t6_busy_cycles", bc, 16);
      check("t6_result", res16, 16'h2233);
      check("t6_flags", {cout16, ovf16}, 2'b00);
      start_op(16, 1'b1, 16'h7FFF, 16'h0001);
      wait_done(16, -1, lat, bc);
      check("t6b_result", res16, 16'h8000);
      check("t6b_flags", {cout16, ovf16}, 2'b01);
      start_op(16, 1'b0, 16'h0000, 16'h0001);
      wait_done(16, -1, lat, bc);
`ifdef SERIAL_SAT_EN
      check("t6c_result", res16, 16'h0000);
`else
      check("t6c_result", res16, 16'hFFFF);
`endif
      check("t6c_flags", {cout16, ovf16}, 2'b10);
      @(negedge CLK);
      check("t6_done_one_cycle", done16, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
